// File: rtl/xy_debouncer.sv
// Two-channel switch debouncer: per-channel 2-flop synchronizer plus a
// STABLE/PENDING qualifier; xy_changed pulses once when either level moves.

module xy_debouncer_chan #(
    parameter int CNT_MAX = 4
) (
    input  logic clk_n,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic update
);
    // state   | meaning
    // STABLE  | synchronized input agrees with level, counter idle at 0
    // PENDING | synchronized input disagrees, counting consecutive cycles

    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic          s1, s2;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          level_nxt;

    always_ff @(posedge clk_n or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk_n or negedge rst) begin
        if (!rst) begin
            state <= ST_STABLE;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        update    = 1'b0;
        case (state)
            ST_STABLE: begin
                if (s2 != level) begin
                    // A single-cycle qualification accepts the new level at once
                    if (CNT_MAX == 1) begin
                        level_nxt = s2;
                        update    = 1'b1;
                    end else begin
                        state_nxt = ST_PENDING;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            ST_PENDING: begin
                if (s2 == level) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_LAST) begin
                    level_nxt = s2;
                    cnt_nxt   = '0;
                    state_nxt = ST_STABLE;
                    update    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = ST_STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end
endmodule

module xy_debouncer #(
    parameter int CNT_MAX = 4
) (
    input  logic clk_n,
    input  logic rst,
    input  logic raw_x,
    input  logic raw_y,
    output logic x,
    output logic y,
    output logic xy_changed
);
    logic upd_x, upd_y;

    xy_debouncer_chan #(.CNT_MAX(CNT_MAX)) u_chan_x (
        .clk_n  (clk_n),
        .rst    (rst),
        .raw    (raw_x),
        .level  (x),
        .update (upd_x)
    );

    xy_debouncer_chan #(.CNT_MAX(CNT_MAX)) u_chan_y (
        .clk_n  (clk_n),
        .rst    (rst),
        .raw    (raw_y),
        .level  (y),
        .update (upd_y)
    );

    // Registered alongside the level flops so the pulse lines up with the new value
    always_ff @(posedge clk_n or negedge rst) begin
        if (!rst) begin
            xy_changed <= 1'b0;
        end else begin
            xy_changed <= upd_x | upd_y;
        end
    end
endmodule

// File: tb/tb_xy_debouncer.sv
// Self-checking bench for xy_debouncer: a CNT_MAX=4 and a CNT_MAX=1 instance
// share stimulus and are checked against a sliding-window reference model.

module tb_xy_debouncer;
    localparam int CM0 = 4;
    localparam int CM1 = 1;

    logic clk_n = 1'b0;
    logic rst;
    logic raw_x, raw_y;
    logic x0, y0, c0;
    logic x1, y1, c1;

    int checks   = 0;
    int failures = 0;
    int pulses0  = 0;

    always #5 clk_n = ~clk_n;

    xy_debouncer #(.CNT_MAX(CM0)) dut (
        .clk_n(clk_n), .rst(rst), .raw_x(raw_x), .raw_y(raw_y),
        .x(x0), .y(y0), .xy_changed(c0)
    );

    xy_debouncer #(.CNT_MAX(CM1)) dut1 (
        .clk_n(clk_n), .rst(rst), .raw_x(raw_x), .raw_y(raw_y),
        .x(x1), .y(y1), .xy_changed(c1)
    );

    // Reference model: [instance][channel]; level flips when the last CNT_MAX
    // synchronized samples all disagree with it.
    bit        m_s1  [2][2];
    bit        m_s2  [2][2];
    bit        m_lvl [2][2];
    bit [15:0] m_win [2][2];
    bit        m_chg [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_chg[m] = 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                m_s1[m][ch]  = 1'b0;
                m_s2[m][ch]  = 1'b0;
                m_lvl[m][ch] = 1'b0;
                m_win[m][ch] = '0;
            end
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            int        cm;
            bit [15:0] mask;
            bit        upd;
            cm   = (m == 0) ? CM0 : CM1;
            mask = 16'((1 << cm) - 1);
            upd  = 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                bit s2p;
                s2p = m_s2[m][ch];
                m_win[m][ch] = {m_win[m][ch][14:0], s2p};
                if (((m_win[m][ch] ^ {16{m_lvl[m][ch]}}) & mask) == mask) begin
                    m_lvl[m][ch] = s2p;
                    upd = 1'b1;
                end
                m_s2[m][ch] = m_s1[m][ch];
                m_s1[m][ch] = (ch == 0) ? raw_x : raw_y;
            end
            m_chg[m] = upd;
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("mdl_x4",  x0, m_lvl[0][0]);
        chk("mdl_y4",  y0, m_lvl[0][1]);
        chk("mdl_c4",  c0, m_chg[0]);
        chk("mdl_x1",  x1, m_lvl[1][0]);
        chk("mdl_y1",  y1, m_lvl[1][1]);
        chk("mdl_c1",  c1, m_chg[1]);
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic cycle(input bit rx, input bit ry);
        raw_x = rx;
        raw_y = ry;
        @(posedge clk_n);
        if (rst) model_edge();
        else     model_reset();
        @(negedge clk_n);
        compare_model();
        if (c0) pulses0++;
    endtask

    // Edges counted from the capture edge (1) until the selected output rises.
    task automatic rise_edges(input bit dx, input bit dy, output int n);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            cycle(dx, dy);
            if ((dx && x0) || (dy && y0)) begin
                n = k;
                break;
            end
        end
    endtask

    typedef struct {
        bit rx, ry;
        bit ex, ey, ec;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int n;
        int xmax;
        int hx, hy;
        bit rx, ry;

        for (int i = 0; i < 14; i++) begin
            tbl[i].rx = (i < 8);
            tbl[i].ry = 1'b0;
            tbl[i].ex = (i >= 5 && i < 13);
            tbl[i].ey = 1'b0;
            tbl[i].ec = (i == 5 || i == 13);
        end

        rst   = 1'b0;
        raw_x = 1'b1;
        raw_y = 1'b1;
        model_reset();
        @(negedge clk_n);

        // Reset held with raw high: everything stays cleared
        for (int i = 0; i < 20; i++) begin
            cycle(1, 1);
            chk("rst_x", x0, 1'b0);
            chk("rst_y", y0, 1'b0);
            chk("rst_c", c0, 1'b0);
        end
        rst = 1'b1;
        for (int i = 0; i < CM0; i++) begin
            cycle(1, 1);
            chk("release_c", c0, 1'b0);
        end
        for (int i = 0; i < 12; i++) cycle(0, 0);

        // Clean step up then down
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].rx, tbl[i].ry);
            chk($sformatf("tbl_x[%0d]", i), x0, tbl[i].ex);
            chk($sformatf("tbl_y[%0d]", i), y0, tbl[i].ey);
            chk($sformatf("tbl_c[%0d]", i), c0, tbl[i].ec);
        end

        // Bounce reject: three cycles high is one short
        pulses0 = 0;
        xmax    = 0;
        for (int i = 0; i < 13; i++) begin
            cycle(i < 3, 0);
            if (x0) xmax = 1;
        end
        chk_int("bounce_x", xmax, 0);
        chk_int("bounce_pulses", pulses0, 0);

        // Bounce then settle: the final 1 is captured at edge 1
        cycle(1, 0);
        cycle(0, 0);
        cycle(1, 0);
        cycle(0, 0);
        rise_edges(1, 0, n);
        chk_int("settle_edges", n, CM0 + 2);
        chk("settle_pulse", c0, 1'b1);
        cycle(1, 0);
        chk("settle_pulse_end", c0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(0, 0);

        // Simultaneous rise: one shared pulse
        pulses0 = 0;
        rise_edges(1, 1, n);
        chk_int("simul_edges", n, CM0 + 2);
        chk("simul_x", x0, 1'b1);
        chk("simul_y", y0, 1'b1);
        chk("simul_c", c0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1, 1);
        chk_int("simul_pulses", pulses0, 1);
        for (int i = 0; i < 10; i++) cycle(0, 0);

        // Reset at count 2 discards the partial qualification
        for (int i = 0; i < 4; i++) cycle(0, 1);
        rst = 1'b0;
        #1;
        chk("midrst_y", y0, 1'b0);
        chk("midrst_c", c0, 1'b0);
        cycle(0, 1);
        cycle(0, 1);
        rst = 1'b1;
        rise_edges(0, 1, n);
        chk_int("midrst_edges", n, CM0 + 2);

        // Asynchronous clear of a set level
        rst = 1'b0;
        #1;
        chk("async_y", y0, 1'b0);
        chk("async_y1", y1, 1'b0);
        cycle(0, 0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) cycle(0, 0);

        // Randomized run with variable hold times and occasional resets
        hx = 0;
        hy = 0;
        rx = 1'b0;
        ry = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (hx == 0) begin
                rx = $urandom_range(1, 0);
                hx = $urandom_range(2 * CM0 + 2, 1);
            end
            if (hy == 0) begin
                ry = $urandom_range(1, 0);
                hy = $urandom_range(2 * CM0 + 2, 1);
            end
            hx--;
            hy--;
            if (rst && $urandom_range(499, 0) == 0) rst = 1'b0;
            else if (!rst && $urandom_range(2, 0) == 0) rst = 1'b1;
            cycle(rx, ry);
        end
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
